// File: rtl/sev_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// sev_seg_scan_driver
//
// Time-multiplexed driver for a multi-digit 7-segment display. A packed hex
// value (plus blank mask and decimal points) is captured into shadow registers
// on a load strobe. The digits are scanned one slot at a time. Each slot lasts
// PRESCALE clocks: one dead cycle with everything off (anti-ghosting), then the
// digit is shown for the rest of the slot. All outputs are registered, so they
// reflect the prescaler/index/shadow state of the previous cycle.
//
// Parameters:
//   NUM_DIGITS     digits scanned (1..8)
//   PRESCALE       clocks per digit slot (>= 2)
//   SEG_ACTIVE_LOW 1 = seg/dp low-true, 0 = high-true
//   AN_ACTIVE_LOW  1 = an low-true, 0 = high-true
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   load         in   capture strobe for value/blank_mask/dp_in (level sampled)
//   value        in   packed nibbles, digit i = value[4i+3:4i]
//   blank_mask   in   1 = digit i forced blank
//   dp_in        in   1 = decimal point lit on digit i
//   seg          out  segments {g,f,e,d,c,b,a}
//   dp           out  decimal point
//   an           out  digit selects, one-hot when active
//   frame        out  one-cycle pulse when the scan index wraps to 0
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, zero nibbles above the most significant nonzero nibble are
//   blanked (digit 0 is never suppressed). Undefined: all zeros are shown.
// -----------------------------------------------------------------------------
module sev_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Inactive output levels depend on the configured polarity.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                              : {NUM_DIGITS{1'b0}};

    // Slot phase: the first cycle of every slot is dead, the rest show a digit.
    localparam logic [0:0] SLOT_DEAD = 1'b0;
    localparam logic [0:0] SLOT_SHOW = 1'b1;

    // Hex to segment pattern, low-true {g,f,e,d,c,b,a}.
    function automatic logic [6:0] dec_low(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [4*NUM_DIGITS-1:0] value_q,  value_d;
    logic [NUM_DIGITS-1:0]   mask_q,   mask_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q,  dp_sh_d;
    logic [PS_W-1:0]         presc_q,  presc_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [6:0]              seg_q,    seg_d;
    logic                    dp_q,     dp_d;
    logic [NUM_DIGITS-1:0]   an_q,     an_d;
    logic                    frame_q,  frame_d;

    logic                    presc_end_s;
    logic [0:0]              slot_s;
    logic [NUM_DIGITS-1:0]   lz_blank_s;
    logic [NUM_DIGITS-1:0]   an_hot_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_blank_s;
    logic                    cur_dp_s;
    logic [6:0]              seg_lit_s;

    // Shadow capture: load is level sampled, so holding it high keeps re-capturing.
    always_comb begin
        if (load) begin
            value_d = value;
            mask_d  = blank_mask;
            dp_sh_d = dp_in;
        end else begin
            value_d = value_q;
            mask_d  = mask_q;
            dp_sh_d = dp_sh_q;
        end
    end

    // Prescaler and scan index; the index advances on the last cycle of a slot.
    always_comb begin
        presc_end_s = (presc_q == PS_LAST);
        if (presc_end_s) begin
            presc_d = {PS_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PS_W'(1);
            idx_d   = idx_q;
        end
        // Registered, so the pulse lands on the same edge as the wrap.
        frame_d = presc_end_s & (idx_q == IDX_LAST);
        slot_s  = (presc_q == {PS_W{1'b0}}) ? SLOT_DEAD : SLOT_SHOW;
    end

    // Leading-zero suppression mask, evaluated on the shadow value.
    always_comb begin
        lz_blank_s = {NUM_DIGITS{1'b0}};
`ifdef LEADING_ZERO_BLANK_EN
        begin : lz_scan
            logic lead_s;
            lead_s = 1'b1;
            // Walk down from the top digit; digit 0 is never suppressed.
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                if (lead_s && (value_q[4*i +: 4] == 4'h0)) begin
                    lz_blank_s[i] = 1'b1;
                end else begin
                    lead_s = 1'b0;
                end
            end
        end
`endif
    end

    // Per-digit selection of nibble, blank and dp for the current scan index.
    always_comb begin
        cur_nib_s   = 4'h0;
        cur_blank_s = 1'b0;
        cur_dp_s    = 1'b0;
        an_hot_s    = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_s   = value_q[4*i +: 4];
                cur_blank_s = mask_q[i] | lz_blank_s[i];
                cur_dp_s    = dp_sh_q[i];
                an_hot_s[i] = 1'b1;
            end else begin
                an_hot_s[i] = 1'b0;
            end
        end
        // Blanking kills the segments only; an and dp keep running.
        if (cur_blank_s) begin
            seg_lit_s = 7'b0000000;
        end else begin
            seg_lit_s = ~dec_low(cur_nib_s);
        end
    end

    // Output levels for the slot phase, with polarity applied.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        case (slot_s)
            SLOT_DEAD: begin
                seg_d = SEG_OFF;
                dp_d  = DP_OFF;
                an_d  = AN_OFF;
            end
            SLOT_SHOW: begin
                seg_d = SEG_ACTIVE_LOW ? ~seg_lit_s : seg_lit_s;
                dp_d  = SEG_ACTIVE_LOW ? ~cur_dp_s  : cur_dp_s;
                an_d  = AN_ACTIVE_LOW  ? ~an_hot_s  : an_hot_s;
            end
            default: begin
                seg_d = SEG_OFF;
                dp_d  = DP_OFF;
                an_d  = AN_OFF;
            end
        endcase
    end

    // Shadow, scan and output registers; reset forces every output inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= {(4*NUM_DIGITS){1'b0}};
            mask_q  <= {NUM_DIGITS{1'b0}};
            dp_sh_q <= {NUM_DIGITS{1'b0}};
            presc_q <= {PS_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            value_q <= value_d;
            mask_q  <= mask_d;
            dp_sh_q <= dp_sh_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Testbench for sev_seg_scan_driver. Three instances share stimulus:
//   dut_a: 4 digits, PRESCALE=4, low-true seg and an
//   dut_b: 4 digits, PRESCALE=3, high-true seg and an
//   dut_c: 1 digit,  PRESCALE=2, low-true seg and an
// Expected outputs come from a model that derives slot position and digit
// from the cycle count since reset with division/modulo.
module tb_sev_seg_scan_driver;

    localparam int PA = 4;
    localparam int PB = 3;
    localparam int PC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_in;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b;
    logic       an_c;
    logic       frame_a, frame_b, frame_c;

    always #5 clk = ~clk;

    sev_seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(PA), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .dp_in(dp_in), .seg(seg_a), .dp(dp_a), .an(an_a), .frame(frame_a));

    sev_seg_scan_driver #(.NUM_DIGITS(4), .PRESCALE(PB), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank_mask(blank_mask),
        .dp_in(dp_in), .seg(seg_b), .dp(dp_b), .an(an_b), .frame(frame_b));

    sev_seg_scan_driver #(.NUM_DIGITS(1), .PRESCALE(PC), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .rst(rst), .load(load), .value(value[3:0]), .blank_mask(blank_mask[0]),
        .dp_in(dp_in[0]), .seg(seg_c), .dp(dp_c), .an(an_c), .frame(frame_c));

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: cycles since reset release and the shadow copy of the inputs.
    int          t;
    logic [15:0] sh_val;
    logic [3:0]  sh_mask, sh_dp;
    exp_t        ea, eb, ec;

    function automatic logic [6:0] dec_low(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Expected outputs after the edge that follows cycle tt (pre-edge shadow v/m/d).
    function automatic exp_t model(input int p, input int n, input bit seg_low, input bit an_low,
                                   input int tt, input logic [15:0] v, input logic [3:0] m,
                                   input logic [3:0] d);
        exp_t       r;
        int         pos, dig;
        bit         lz;
        logic [6:0] lit;
        logic       dpl;
        logic [3:0] on;
        pos = tt % p;
        dig = (tt / p) % n;
        lit = 7'b0000000;
        dpl = 1'b0;
        on  = 4'b0000;
        lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int top;
            top = 0;
            for (int i = 0; i < n; i++) if (v[4*i +: 4] != 4'h0) top = i;
            lz = (dig > top);
        end
`endif
        if (pos != 0) begin
            on[dig] = 1'b1;
            dpl     = d[dig];
            if (!m[dig] && !lz) lit = ~dec_low(v[4*dig +: 4]);
        end
        r.seg   = seg_low ? ~lit : lit;
        r.dp    = seg_low ? ~dpl : dpl;
        r.an    = an_low ? ~on : on;
        r.frame = (pos == p - 1) && (dig == n - 1);
        return r;
    endfunction

    task automatic model_reset();
        t       = 0;
        sh_val  = 16'h0000;
        sh_mask = 4'h0;
        sh_dp   = 4'h0;
    endtask

    // Advance one clock: predict from pre-edge state, then update the model.
    task automatic tick();
        ea = model(PA, 4, 1'b1, 1'b1, t, sh_val, sh_mask, sh_dp);
        eb = model(PB, 4, 1'b0, 1'b0, t, sh_val, sh_mask, sh_dp);
        ec = model(PC, 1, 1'b1, 1'b1, t, sh_val & 16'h000F, sh_mask & 4'h1, sh_dp & 4'h1);
        @(posedge clk);
        #1;
        if (load) begin
            sh_val  = value;
            sh_mask = blank_mask;
            sh_dp   = dp_in;
        end
        t++;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = 16'h0000; blank_mask = 4'h0; dp_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({seg_a, dp_a, an_a, frame_a} !== {7'b1111111, 1'b1, 4'b1111, 1'b0})
            $display("FAIL reset_a got %b exp %b", {seg_a, dp_a, an_a, frame_a}, {7'b1111111, 1'b1, 4'b1111, 1'b0});
        else n_pass++;
        n_checks++;
        if ({seg_b, dp_b, an_b, frame_b} !== 13'b0)
            $display("FAIL reset_b got %b exp %b", {seg_b, dp_b, an_b, frame_b}, 13'b0);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({seg_a, dp_a, an_a, frame_a} !== ea)
                $display("FAIL post_reset_a i=%0d got %b exp %b", i, {seg_a, dp_a, an_a, frame_a}, ea);
            else n_pass++;
            n_checks++;
            if ({seg_c, dp_c, an_c, frame_c} !== {ec.seg, ec.dp, ec.an[0], ec.frame})
                $display("FAIL post_reset_c i=%0d got %b exp %b", i, {seg_c, dp_c, an_c, frame_c}, {ec.seg, ec.dp, ec.an[0], ec.frame});
            else n_pass++;
            if (i < 2) begin
                n_checks++;
                if (an_a !== ((i == 0) ? 4'b1111 : 4'b1110))
                    $display("FAIL first_show i=%0d got an=%b exp %b", i, an_a, (i == 0) ? 4'b1111 : 4'b1110);
                else n_pass++;
            end
        end
        // Mid-cycle asynchronous reset while digit 2 is displayed.
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({seg_a, dp_a, an_a, frame_a} !== {7'b1111111, 1'b1, 4'b1111, 1'b0})
            $display("FAIL async_reset_a got %b exp %b", {seg_a, dp_a, an_a, frame_a}, {7'b1111111, 1'b1, 4'b1111, 1'b0});
        else n_pass++;
        n_checks++;
        if ({seg_b, dp_b, an_b, frame_b} !== 13'b0)
            $display("FAIL async_reset_b got %b exp %b", {seg_b, dp_b, an_b, frame_b}, 13'b0);
        else n_pass++;
        n_checks++;
        if ({seg_c, dp_c, an_c, frame_c} !== {7'b1111111, 1'b1, 1'b1, 1'b0})
            $display("FAIL async_reset_c got %b exp %b", {seg_c, dp_c, an_c, frame_c}, {7'b1111111, 1'b1, 1'b1, 1'b0});
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_scan();
        logic [6:0] dig_seg [4];
        logic [3:0] sel;
        int         frames;
        dig_seg = '{7'b0001110, 7'b0000110, 7'b0100100, 7'b1111001};
        value = 16'h12EF; blank_mask = 4'h0; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        frames = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (frame_a) frames++;
            n_checks++;
            if ({seg_a, dp_a, an_a, frame_a} !== ea)
                $display("FAIL scan_a t=%0d got %b exp %b", t, {seg_a, dp_a, an_a, frame_a}, ea);
            else n_pass++;
            n_checks++;
            if ({seg_b, dp_b, an_b, frame_b} !== eb)
                $display("FAIL scan_b t=%0d got %b exp %b", t, {seg_b, dp_b, an_b, frame_b}, eb);
            else n_pass++;
            for (int k = 0; k < 4; k++) begin
                sel = 4'b1111 ^ (4'b0001 << k);
                if (an_a == sel) begin
                    n_checks++;
                    if (seg_a !== dig_seg[k])
                        $display("FAIL scan_digit%0d got seg=%b exp %b", k, seg_a, dig_seg[k]);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (frames != 2) $display("FAIL frame_count got %0d exp 2", frames);
        else n_pass++;
    endtask

    task automatic test_blank_dp();
        value = 16'h12EF; blank_mask = 4'b0100; dp_in = 4'b0001; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({seg_a, dp_a, an_a, frame_a} !== ea)
                $display("FAIL blank_a t=%0d got %b exp %b", t, {seg_a, dp_a, an_a, frame_a}, ea);
            else n_pass++;
            n_checks++;
            if ({seg_b, dp_b, an_b, frame_b} !== eb)
                $display("FAIL blank_b t=%0d got %b exp %b", t, {seg_b, dp_b, an_b, frame_b}, eb);
            else n_pass++;
            if (an_a == 4'b1011) begin
                n_checks++;
                if (seg_a !== 7'b1111111) $display("FAIL blank_digit2 got seg=%b exp 1111111", seg_a);
                else n_pass++;
            end
            if (an_a != 4'b1111) begin
                n_checks++;
                if (dp_a !== ((an_a == 4'b1110) ? 1'b0 : 1'b1))
                    $display("FAIL dp_digit an=%b got dp=%b exp %b", an_a, dp_a, (an_a == 4'b1110) ? 1'b0 : 1'b1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_at_slot_end();
        value = 16'h12EF; blank_mask = 4'h0; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        // Advance until the next edge is the slot end of digit 1 on dut_a.
        for (int i = 0; i < 20 && !((t % PA == PA - 1) && ((t / PA) % 4 == 1)); i++) tick();
        n_checks++;
        if (!((t % PA == PA - 1) && ((t / PA) % 4 == 1))) $display("FAIL slot_end_search t=%0d", t);
        else n_pass++;
        value = 16'hAAAA; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({seg_a, dp_a, an_a, frame_a} !== ea)
                $display("FAIL slot_end_a i=%0d got %b exp %b", i, {seg_a, dp_a, an_a, frame_a}, ea);
            else n_pass++;
        end
        n_checks++;
        if ({an_a, seg_a} !== {4'b1011, 7'b0001000})
            $display("FAIL slot_end_digit2 got an=%b seg=%b exp an=1011 seg=0001000", an_a, seg_a);
        else n_pass++;
    endtask

    task automatic test_polarity();
        value = 16'h8888; blank_mask = 4'h0; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2 * PB * 4; i++) begin
            tick();
            n_checks++;
            if ({seg_b, dp_b, an_b, frame_b} !== eb)
                $display("FAIL polarity_b t=%0d got %b exp %b", t, {seg_b, dp_b, an_b, frame_b}, eb);
            else n_pass++;
            n_checks++;
            if (an_b == 4'b0000) begin
                if (seg_b !== 7'b0000000) $display("FAIL polarity_dead got seg=%b exp 0000000", seg_b);
                else n_pass++;
            end else begin
                if (seg_b !== 7'b1111111 || !$onehot(an_b))
                    $display("FAIL polarity_show got seg=%b an=%b exp seg=1111111 an one-hot", seg_b, an_b);
                else n_pass++;
            end
        end
    endtask

    task automatic test_zero_digits();
        logic [6:0] lead_exp;
`ifdef LEADING_ZERO_BLANK_EN
        lead_exp = 7'b1111111;
`else
        lead_exp = 7'b1000000;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            value = (pass == 0) ? 16'h0050 : 16'h0000;
            blank_mask = 4'h0; dp_in = 4'h0; load = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                n_checks++;
                if ({seg_a, dp_a, an_a, frame_a} !== ea)
                    $display("FAIL zeros_a v=%h t=%0d got %b exp %b", value, t, {seg_a, dp_a, an_a, frame_a}, ea);
                else n_pass++;
                if (an_a == 4'b0111 || (pass == 1 && an_a == 4'b1101)) begin
                    n_checks++;
                    if (seg_a !== lead_exp)
                        $display("FAIL leading_zero v=%h an=%b got seg=%b exp %b", value, an_a, seg_a, lead_exp);
                    else n_pass++;
                end
                if (an_a == 4'b1110) begin
                    n_checks++;
                    if (seg_a !== 7'b1000000) $display("FAIL digit0_zero got seg=%b exp 1000000", seg_a);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] prev_an;
        int         frames_c;
        prev_an  = an_a;
        frames_c = 0;
        for (int i = 0; i < 300; i++) begin
            load       = ($urandom_range(0, 3) == 0);
            value      = 16'($urandom);
            blank_mask = 4'($urandom);
            dp_in      = 4'($urandom);
            if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
            tick();
            if (frame_c) frames_c++;
            n_checks++;
            if ({seg_a, dp_a, an_a, frame_a} !== ea)
                $display("FAIL rand_a t=%0d got %b exp %b", t, {seg_a, dp_a, an_a, frame_a}, ea);
            else n_pass++;
            n_checks++;
            if ({seg_b, dp_b, an_b, frame_b} !== eb)
                $display("FAIL rand_b t=%0d got %b exp %b", t, {seg_b, dp_b, an_b, frame_b}, eb);
            else n_pass++;
            n_checks++;
            if ({seg_c, dp_c, an_c, frame_c} !== {ec.seg, ec.dp, ec.an[0], ec.frame})
                $display("FAIL rand_c t=%0d got %b exp %b", t, {seg_c, dp_c, an_c, frame_c}, {ec.seg, ec.dp, ec.an[0], ec.frame});
            else n_pass++;
            // A change of active digit must pass through an all-inactive cycle.
            n_checks++;
            if ($countones(~an_a) > 1 || (prev_an != 4'b1111 && an_a != 4'b1111 && prev_an != an_a))
                $display("FAIL glitch prev an=%b got an=%b exp single digit with dead gap", prev_an, an_a);
            else n_pass++;
            prev_an = an_a;
        end
        load = 1'b0;
        n_checks++;
        if (frames_c != 300 / PC) $display("FAIL single_digit_frames got %0d exp %0d", frames_c, 300 / PC);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_dp();
        test_load_at_slot_end();
        test_polarity();
        test_zero_digits();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
